wave_meter: RTL and testbench

Measurement block for the signal-generator path. It takes the 10-bit sample stream produced by the DDS output stage, or read back from the ADC in loop-back, and measures the waveform period in clock cycles plus its maximum, minimum and peak-to-peak amplitude. Rising crossings of a programmable level are detected with hysteresis. Each full period produces one result record, used to check the generator's frequency and amplitude settings.

---
 rtl/wave_meter.sv | 208 ++++++++++++++++++++
 tb/tb_wave_meter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_meter.sv
// wave_meter: period and amplitude meter for the DDS / ADC loop-back sample stream.
// Hysteretic rising-level trigger; one registered result record per full period.
module wave_meter #(
    parameter int unsigned      DW      = 10,
    parameter int unsigned      CNT_W   = 24,
    parameter int unsigned      HYST    = 8,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_en,
    input  logic [DW-1:0]    level,
    input  logic [DW-1:0]    sample_in,
    input  logic             sample_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [DW-1:0]    vmax_out,
    output logic [DW-1:0]    vmin_out,
    output logic [DW-1:0]    vpp_out,
    output logic             result_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FIRST,
        S_MEAS
    } state_e;

    localparam logic [DW-1:0] HYST_V = DW'(HYST);

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    rmax_q, rmax_d;
    logic [DW-1:0]    rmin_q, rmin_d;

    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pper_q, pper_d;
    logic [DW-1:0]    pmax_q, pmax_d;
    logic [DW-1:0]    pmin_q, pmin_d;
    logic             tout_d;

    logic [CNT_W-1:0] period_q;
    logic [DW-1:0]    vmax_q, vmin_q, vpp_q;
    logic             rvalid_q, tout_q;

    logic [DW-1:0]    lo_th;
    logic             arm_hit, trig, to_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [DW-1:0]    max_in, min_in;

    // Arm threshold saturates at zero; a sample at or below it arms rather than triggers.
    assign lo_th   = (level >= HYST_V) ? level - HYST_V : '0;
    assign arm_hit = sample_valid && (sample_in <= lo_th);
    assign trig    = sample_valid && armed_q && !arm_hit && (sample_in >= level);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign to_hit  = (cnt_inc == TIMEOUT);
    assign max_in  = (sample_in > rmax_q) ? sample_in : rmax_q;
    assign min_in  = (sample_in < rmin_q) ? sample_in : rmin_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: abort first, then trigger before timeout in the measuring states.
    always_comb begin
        state_d = state_q;
        if (!meas_en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_ARM;
                S_ARM: begin
                    if (to_hit)       state_d = S_ARM;
                    else if (arm_hit) state_d = S_FIRST;
                end
                S_FIRST: begin
                    if (trig)        state_d = S_MEAS;
                    else if (to_hit) state_d = S_ARM;
                end
                S_MEAS: begin
                    if (trig)        state_d = S_MEAS;
                    else if (to_hit) state_d = S_ARM;
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Arming, period counter, running extremes and capture of a finished period.
    always_comb begin
        armed_d = armed_q;
        cnt_d   = cnt_q;
        rmax_d  = rmax_q;
        rmin_d  = rmin_q;
        pend_d  = 1'b0;
        pper_d  = pper_q;
        pmax_d  = pmax_q;
        pmin_d  = pmin_q;
        tout_d  = 1'b0;
        if (!meas_en) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    armed_d = 1'b0;
                    cnt_d   = '0;
                end
                S_ARM: begin
                    cnt_d = cnt_inc;
                    if (to_hit) begin
                        tout_d  = 1'b1;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end else if (arm_hit) begin
                        armed_d = 1'b1;
                    end
                end
                S_FIRST, S_MEAS: begin
                    cnt_d = cnt_inc;
                    if (trig) begin
                        armed_d = 1'b0;
                        cnt_d   = CNT_W'(1);
                        rmax_d  = sample_in;
                        rmin_d  = sample_in;
                        if (state_q == S_MEAS) begin
                            pend_d = 1'b1;
                            pper_d = cnt_q;
                            pmax_d = max_in;
                            pmin_d = min_in;
                        end
                    end else if (to_hit) begin
                        tout_d  = 1'b1;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end else if (sample_valid) begin
                        if (arm_hit) armed_d = 1'b1;
                        if (state_q == S_MEAS) begin
                            rmax_d = max_in;
                            rmin_d = min_in;
                        end
                    end
                end
            endcase
        end
    end

    // Measurement state and the one-deep capture stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
            rmax_q  <= '0;
            rmin_q  <= '0;
            pend_q  <= 1'b0;
            pper_q  <= '0;
            pmax_q  <= '0;
            pmin_q  <= '0;
        end else begin
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            rmax_q  <= rmax_d;
            rmin_q  <= rmin_d;
            pend_q  <= pend_d;
            pper_q  <= pper_d;
            pmax_q  <= pmax_d;
            pmin_q  <= pmin_d;
        end
    end

    // Registered result outputs; they hold until the next captured period.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            vmax_q   <= '0;
            vmin_q   <= '0;
            vpp_q    <= '0;
            rvalid_q <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            rvalid_q <= pend_q;
            tout_q   <= tout_d;
            if (pend_q) begin
                period_q <= pper_q;
                vmax_q   <= pmax_q;
                vmin_q   <= pmin_q;
                vpp_q    <= pmax_q - pmin_q;
            end
        end
    end

    assign period_out   = period_q;
    assign vmax_out     = vmax_q;
    assign vmin_out     = vmin_q;
    assign vpp_out      = vpp_q;
    assign result_valid = rvalid_q;
    assign timeout      = tout_q;

endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: scoreboard bench for wave_meter.
// Edge-indexed reference model feeds expected results/timeouts to a monitor.
module tb_wave_meter;

    localparam int TO = 1000;
    localparam int HY = 8;

    typedef struct packed {
        int          e;
        logic [23:0] per;
        logic [9:0]  mx;
        logic [9:0]  mn;
        logic [9:0]  pp;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, meas_en, sample_valid;
    logic [9:0]  level, sample_in;
    logic [23:0] period_out;
    logic [9:0]  vmax_out, vmin_out, vpp_out;
    logic        result_valid, timeout, busy;

    wave_meter #(
        .DW(10), .CNT_W(24), .HYST(HY), .TIMEOUT(24'd1000)
    ) dut (
        .clk(clk), .rst(rst), .meas_en(meas_en), .level(level),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .period_out(period_out), .vmax_out(vmax_out), .vmin_out(vmin_out),
        .vpp_out(vpp_out), .result_valid(result_valid), .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;
    int n_res = 0;
    int n_to  = 0;

    res_t exp_res[$];
    int   exp_to[$];

    // model: 0 off, 1 seeking arm, 2 seeking first trigger, 3 measuring
    int         ph = 0;
    bit         armed_m = 0;
    int         z = 0;
    int         t0 = 0;
    logic [9:0] mx, mn;

    task automatic model(input int e, input bit r, input bit en,
                         input int lv, input bit v, input int s);
        int   lo;
        bit   arm, trig, to;
        res_t x;
        if (r) begin
            ph = 0;
            armed_m = 0;
            for (int i = exp_res.size() - 1; i >= 0; i--)
                if (exp_res[i].e >= e) exp_res.delete(i);
            return;
        end
        if (!en) begin
            ph = 0;
            armed_m = 0;
            return;
        end
        lo   = (lv >= HY) ? lv - HY : 0;
        arm  = v && (s <= lo);
        trig = v && armed_m && !arm && (s >= lv);
        to   = (e - z) == TO;
        if (ph == 0) begin
            ph = 1;
            z = e;
            armed_m = 0;
        end else if (ph == 1) begin
            if (to) begin
                exp_to.push_back(e);
                z = e;
            end else if (arm) begin
                armed_m = 1;
                ph = 2;
            end
        end else begin
            if (trig) begin
                if (ph == 3) begin
                    x.e   = e + 1;
                    x.per = 24'(e - t0);
                    x.mx  = (10'(s) > mx) ? 10'(s) : mx;
                    x.mn  = (10'(s) < mn) ? 10'(s) : mn;
                    x.pp  = x.mx - x.mn;
                    exp_res.push_back(x);
                end
                ph = 3;
                armed_m = 0;
                t0 = e;
                z = e - 1;
                mx = 10'(s);
                mn = 10'(s);
            end else if (to) begin
                exp_to.push_back(e);
                ph = 1;
                z = e;
                armed_m = 0;
            end else if (v) begin
                if (arm) armed_m = 1;
                if (ph == 3) begin
                    if (10'(s) > mx) mx = 10'(s);
                    if (10'(s) < mn) mn = 10'(s);
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input int lv,
                        input bit v, input int s);
        rst = r;
        meas_en = en;
        level = 10'(lv);
        sample_valid = v;
        sample_in = 10'(s);
        model(edge_n + 1, r, en, lv, v, s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    res_t m;
    int   te;

    // monitor: pop and compare whenever the DUT pulses an output
    always @(negedge clk) begin
        tests++;
        if (result_valid && timeout) begin
            fails++;
            $display("FAIL overlap: result_valid and timeout both high at edge %0d",
                     edge_n);
        end
        while (exp_res.size() > 0 && exp_res[0].e < edge_n) begin
            tests++;
            fails++;
            $display("FAIL missing_result: got no pulse, want one at edge %0d",
                     exp_res[0].e);
            exp_res.delete(0);
        end
        while (exp_to.size() > 0 && exp_to[0] < edge_n) begin
            tests++;
            fails++;
            $display("FAIL missing_timeout: got no pulse, want one at edge %0d",
                     exp_to[0]);
            exp_to.delete(0);
        end
        if (result_valid) begin
            n_res++;
            tests++;
            if (exp_res.size() > 0 && exp_res[0].e == edge_n) begin
                m = exp_res.pop_front();
                if (period_out !== m.per || vmax_out !== m.mx ||
                    vmin_out !== m.mn || vpp_out !== m.pp) begin
                    fails++;
                    $display("FAIL result@%0d: got p=%0d max=%0d min=%0d pp=%0d, want p=%0d max=%0d min=%0d pp=%0d",
                             edge_n, period_out, vmax_out, vmin_out, vpp_out,
                             m.per, m.mx, m.mn, m.pp);
                end
            end else begin
                fails++;
                $display("FAIL unexpected_result: got result_valid at edge %0d, want none",
                         edge_n);
            end
        end
        if (timeout) begin
            n_to++;
            tests++;
            if (exp_to.size() > 0 && exp_to[0] == edge_n) begin
                te = exp_to.pop_front();
            end else begin
                fails++;
                $display("FAIL unexpected_timeout: got timeout at edge %0d, want none",
                         edge_n);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    int r0, t0c;

    initial begin
        rst = 1'b1;
        meas_en = 1'b0;
        level = 10'd512;
        sample_valid = 1'b0;
        sample_in = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 0, 512, 0, 0);
        chk("rst_period", 64'(period_out), 0);
        chk("rst_vmax", 64'(vmax_out), 0);
        chk("rst_vmin", 64'(vmin_out), 0);
        chk("rst_vpp", 64'(vpp_out), 0);
        chk("rst_rvalid", 64'(result_valid), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_busy", 64'(busy), 0);

        // square wave 100/900, 50 clocks each
        step(0, 0, 512, 0, 0);
        r0 = n_res;
        for (int p = 0; p < 6; p++)
            for (int c = 0; c < 100; c++)
                step(0, 1, 512, 1, (c < 50) ? 100 : 900);
        chk("sq_busy", 64'(busy), 1);
        chk("sq_count", 64'(n_res - r0), 5);
        chk("sq_period", 64'(period_out), 100);
        chk("sq_vmax", 64'(vmax_out), 900);
        chk("sq_vmin", 64'(vmin_out), 100);
        chk("sq_vpp", 64'(vpp_out), 800);

        // same wave, valid every other clock, 100 clocks per half
        step(0, 0, 512, 0, 0);
        r0 = n_res;
        for (int c = 0; c < 600; c++)
            step(0, 1, 512, (c % 2) == 0, ((c / 100) % 2) ? 900 : 100);
        chk("half_count", 64'(n_res - r0), 2);
        chk("half_period", 64'(period_out), 200);

        // noise around level never arms
        step(0, 0, 512, 0, 0);
        r0 = n_res;
        t0c = n_to;
        for (int c = 0; c < 3050; c++)
            step(0, 1, 512, 1, (c % 2) ? 516 : 508);
        chk("noise_results", 64'(n_res - r0), 0);
        chk("noise_timeouts", 64'(n_to - t0c), 3);
        chk("noise_hold", 64'(period_out), 200);

        // exact lo_th arms; unarmed 520 does not trigger
        step(0, 0, 512, 0, 0);
        step(0, 1, 512, 0, 0);
        step(0, 1, 512, 1, 600);
        step(0, 1, 512, 1, 504);
        step(0, 1, 512, 1, 512);
        for (int i = 0; i < 5; i++) step(0, 1, 512, 1, 520);
        step(0, 1, 512, 1, 504);
        step(0, 1, 512, 1, 512);
        step(0, 1, 512, 0, 0);
        step(0, 1, 512, 0, 0);
        chk("lo_period", 64'(period_out), 7);
        chk("lo_vmax", 64'(vmax_out), 520);
        chk("lo_vmin", 64'(vmin_out), 504);
        chk("lo_vpp", 64'(vpp_out), 16);

        // abort on the same cycle as the second trigger
        step(0, 0, 512, 0, 0);
        step(0, 1, 512, 0, 0);
        step(0, 1, 512, 1, 504);
        step(0, 1, 512, 1, 512);
        for (int i = 0; i < 3; i++) step(0, 1, 512, 1, 600);
        step(0, 1, 512, 1, 504);
        r0 = n_res;
        step(0, 0, 512, 1, 512);
        chk("abort_busy", 64'(busy), 0);
        step(0, 0, 512, 0, 0);
        step(0, 0, 512, 0, 0);
        chk("abort_nores", 64'(n_res - r0), 0);
        chk("abort_hold_p", 64'(period_out), 7);
        chk("abort_hold_max", 64'(vmax_out), 520);

        // lo_th saturates at zero for a small level
        step(0, 1, 4, 0, 0);
        step(0, 1, 4, 1, 0);
        step(0, 1, 4, 1, 4);
        step(0, 1, 4, 1, 1);
        step(0, 1, 4, 1, 0);
        step(0, 1, 4, 1, 1);
        step(0, 1, 4, 1, 4);
        step(0, 1, 4, 0, 0);
        step(0, 1, 4, 0, 0);
        chk("sat_period", 64'(period_out), 4);
        chk("sat_vmax", 64'(vmax_out), 4);
        chk("sat_vmin", 64'(vmin_out), 0);
        step(0, 1, 4, 1, 2);
        step(0, 1, 4, 1, 3);
        step(1, 1, 4, 1, 3);
        chk("mrst_period", 64'(period_out), 0);
        chk("mrst_vmax", 64'(vmax_out), 0);
        chk("mrst_vpp", 64'(vpp_out), 0);
        chk("mrst_busy", 64'(busy), 0);

        // randomized traffic
        begin
            int lv;
            lv = 512;
            for (int c = 0; c < 4000; c++) begin
                if (c % 64 == 0)
                    lv = ($urandom % 4 == 0) ? int'($urandom_range(0, 12))
                                             : int'($urandom_range(0, 1023));
                step(($urandom % 300) == 0, ($urandom % 150) != 0, lv,
                     ($urandom % 4) != 0, int'($urandom_range(0, 1023)));
            end
        end

        for (int i = 0; i < 5; i++) step(0, 0, 512, 0, 0);
        chk("drain_results", 64'(exp_res.size()), 0);
        chk("drain_timeouts", 64'(exp_to.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
